// File: rtl/pe_stream_driver.sv
// pe_stream_driver: issues operand pairs to the single-op PE and queues its results behind a credit-checked FIFO
module pe_stream_driver #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               cfg_we,
  input  logic [1:0]         cfg_inst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic [1:0]         pe_inst,
  output logic [2*WIDTH-1:0] pe_inputs,
  output logic               pe_clk_en,
  input  logic [WIDTH-1:0]   pe_O,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_zero,
  output logic [CNT_W-1:0]   op_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [1:0]         inst_q, inst_d, pe_inst_q, pe_inst_d;
  logic [2*WIDTH-1:0] pe_inputs_q, pe_inputs_d;
  logic               issue_v_q;
  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [DEPTH-1:0]   zero_q;
  logic [AW-1:0]      wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]      count_q, count_d;
  logic [CNT_W-1:0]   op_q, op_d;
  logic               accept, push, pop;
  // The in-flight op holds a credit, so the capture stage can never find the FIFO full
  assign in_ready  = !RESET && (count_q + CW'(issue_v_q) < CW'(DEPTH));
  assign accept    = in_valid && in_ready;
  assign push      = issue_v_q;
  assign pop       = out_valid && out_ready;
  assign out_valid = count_q != '0;
  assign out_data  = mem_q[rd_q];
  assign out_zero  = zero_q[rd_q];
  assign pe_inst   = pe_inst_q;
  assign pe_inputs = pe_inputs_q;
  assign pe_clk_en = issue_v_q;
  assign op_count  = op_q;
  always_comb begin
    inst_d      = cfg_we ? cfg_inst : inst_q;
    pe_inst_d   = accept ? inst_q : pe_inst_q;
    pe_inputs_d = accept ? {in_b, in_a} : pe_inputs_q;
    wr_d        = wr_q + AW'(push);
    rd_d        = rd_q + AW'(pop);
    count_d     = count_q + CW'(push) - CW'(pop);
    op_d        = op_q + CNT_W'(push);
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      inst_q      <= '0;
      pe_inst_q   <= '0;
      pe_inputs_q <= '0;
      issue_v_q   <= 1'b0;
      wr_q        <= '0;
      rd_q        <= '0;
      count_q     <= '0;
      op_q        <= '0;
      zero_q      <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      inst_q      <= inst_d;
      pe_inst_q   <= pe_inst_d;
      pe_inputs_q <= pe_inputs_d;
      issue_v_q   <= accept;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      count_q     <= count_d;
      op_q        <= op_d;
      if (push) begin
        mem_q[wr_q]  <= pe_O;
        zero_q[wr_q] <= pe_O == '0;
      end
    end
  end
endmodule

// File: tb/tb_pe_stream_driver.sv
// tb_pe_stream_driver: queue-based reference model with per-cycle compare plus directed literal checks
module tb_pe_stream_driver;
  localparam int W = 16;
  localparam int D = 4;
  logic CLK = 0, RESET = 1, cfg_we = 0, in_valid = 0, out_ready = 0;
  logic [1:0] cfg_inst = 0;
  logic [W-1:0] in_a = 0, in_b = 0;
  logic in_ready, pe_clk_en, out_valid, out_zero;
  logic [1:0] pe_inst;
  logic [2*W-1:0] pe_inputs;
  logic [W-1:0] pe_O, out_data;
  logic [15:0] op_count;
  int n_cmp = 0, n_bad = 0;

  function automatic logic [W-1:0] alu(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    return op == 2'd0 ? (a | b) : op == 2'd1 ? (a & b) : (a ^ b);
  endfunction

  assign pe_O = alu(pe_inst, pe_inputs[W-1:0], pe_inputs[2*W-1:W]);

  pe_stream_driver #(.WIDTH(W), .DEPTH(D), .CNT_W(16)) dut (
    .CLK(CLK), .RESET(RESET), .cfg_we(cfg_we), .cfg_inst(cfg_inst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .pe_inst(pe_inst), .pe_inputs(pe_inputs), .pe_clk_en(pe_clk_en), .pe_O(pe_O),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_zero(out_zero), .op_count(op_count)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: results queue, one in-flight slot, current instruction
  logic [W-1:0] m_fifo[$];
  logic [W-1:0] m_pops[$];
  logic [1:0] m_inst, m_peinst;
  logic [2*W-1:0] m_inputs;
  logic m_infl;
  logic [W-1:0] m_res;
  logic [15:0] m_cnt;
  int m_acc_n = 0;
  bit started = 0;

  always @(posedge CLK) begin
    if (RESET) begin
      started = 1;
      m_fifo.delete();
      m_inst = 0; m_peinst = 0; m_inputs = 0; m_infl = 0; m_res = 0; m_cnt = 0;
    end else if (started) begin
      automatic bit acc = in_valid && (m_fifo.size() + int'(m_infl) < D);
      if (m_fifo.size() > 0 && out_ready) m_pops.push_back(m_fifo.pop_front());
      if (m_infl) begin
        m_fifo.push_back(m_res);
        m_cnt++;
      end
      m_infl = acc;
      if (acc) begin
        m_res = alu(m_inst, in_a, in_b);
        m_inputs = {in_b, in_a};
        m_peinst = m_inst;
        m_acc_n++;
      end
      if (cfg_we) m_inst = cfg_inst;
    end
  end

  logic prev_stall = 0;
  logic [W-1:0] prev_data;
  always @(negedge CLK) begin
    if (started) begin
      chk("in_ready", in_ready, !RESET && (m_fifo.size() + int'(m_infl) < D));
      chk("out_valid", out_valid, m_fifo.size() > 0);
      chk("out_data_known", $isunknown(out_data), 0);
      if (m_fifo.size() > 0) begin
        chk("out_data", out_data, m_fifo[0]);
        chk("out_zero", out_zero, m_fifo[0] == 0);
      end
      if (prev_stall && out_valid) chk("stall_stable", out_data, prev_data);
      chk("pe_clk_en", pe_clk_en, m_infl);
      chk("pe_inputs", pe_inputs, m_inputs);
      chk("pe_inst", pe_inst, m_peinst);
      chk("op_count", op_count, m_cnt);
      prev_stall = out_valid && !out_ready;
      prev_data = out_data;
    end
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  logic [W-1:0] a_arr [8];
  logic [W-1:0] b_arr [8];
  int acc0, zeros;
  logic [15:0] c0;

  initial begin
    repeat (2) cyc();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_pe_inputs", pe_inputs, 0);
    chk("rst_op_count", op_count, 0);
    RESET = 0;
    cfg_we = 1; cfg_inst = 0;
    cyc();
    cfg_we = 0; in_valid = 1; in_a = 16'h00F0; in_b = 16'h0F00;
    cyc();
    in_valid = 0;
    chk("t1_pe_inputs", pe_inputs, 32'h0F0000F0);
    chk("t1_clk_en", pe_clk_en, 1);
    chk("t1_valid_early", out_valid, 0);
    cyc();
    chk("t1_valid", out_valid, 1);
    chk("t1_data", out_data, 16'h0FF0);
    chk("t1_zero", out_zero, 0);
    chk("t1_count", op_count, 1);
    out_ready = 1;
    cyc();
    out_ready = 0;
    m_pops.delete();
    cfg_we = 1; cfg_inst = 1; in_valid = 1; in_a = 16'hFFFF; in_b = 16'h1234;
    cyc();
    cfg_we = 0;
    cyc();
    in_valid = 0; out_ready = 1;
    repeat (4) cyc();
    out_ready = 0;
    chk("t2_n", m_pops.size(), 2);
    if (m_pops.size() == 2) begin
      chk("t2_old_inst", m_pops[0], 16'hFFFF);
      chk("t2_new_inst", m_pops[1], 16'h1234);
    end
    cfg_we = 1; cfg_inst = 2;
    cyc();
    cfg_we = 0;
    m_pops.delete();
    acc0 = m_acc_n; c0 = op_count;
    for (int i = 0; i < 8; i++) begin
      a_arr[i] = W'($urandom); b_arr[i] = W'($urandom);
      in_valid = 1; in_a = a_arr[i]; in_b = b_arr[i];
      cyc();
    end
    in_valid = 0;
    cyc();
    chk("t3_accepts", m_acc_n - acc0, 4);
    chk("t3_in_ready", in_ready, 0);
    chk("t3_held", op_count - c0, 16'd4);
    out_ready = 1;
    repeat (6) cyc();
    out_ready = 0;
    chk("t3_pops", m_pops.size(), 4);
    if (m_pops.size() == 4)
      for (int i = 0; i < 4; i++) chk("t3_order", m_pops[i], a_arr[i] ^ b_arr[i]);
    m_pops.delete();
    acc0 = m_acc_n;
    out_ready = 1;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1; in_a = W'(i); in_b = W'(i);
      cyc();
    end
    in_valid = 0;
    repeat (4) cyc();
    chk("t4_accepts", m_acc_n - acc0, 20);
    chk("t4_pops", m_pops.size(), 20);
    zeros = 0;
    foreach (m_pops[i]) if (m_pops[i] == 0) zeros++;
    chk("t4_zeros", zeros, 20);
    acc0 = m_acc_n;
    for (int c = 0; c < 3000 && m_acc_n - acc0 < 200; c++) begin
      in_valid = $urandom_range(0, 9) < 7;
      in_a = W'($urandom);
      in_b = ($urandom_range(0, 7) == 0) ? in_a : W'($urandom);
      out_ready = $urandom_range(0, 1) == 1;
      cfg_we = $urandom_range(0, 9) == 0;
      cfg_inst = 2'($urandom);
      cyc();
    end
    in_valid = 0; cfg_we = 0; out_ready = 1;
    chk("t5_accepts", m_acc_n - acc0 >= 200, 1);
    repeat (8) cyc();
    out_ready = 0;
    c0 = op_count;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1; in_a = W'($urandom); in_b = W'($urandom);
      cyc();
    end
    in_valid = 0;
    chk("t6_held", op_count - c0, 16'd3);
    chk("t6_inflight", pe_clk_en, 1);
    RESET = 1;
    cyc();
    chk("t6_valid", out_valid, 0);
    chk("t6_count", op_count, 0);
    chk("t6_clk_en", pe_clk_en, 0);
    RESET = 0;
    m_pops.delete();
    in_valid = 1; in_a = 16'h0003; in_b = 16'h0005;
    cyc();
    in_valid = 0; out_ready = 1;
    repeat (4) cyc();
    chk("t6_one_pop", m_pops.size(), 1);
    if (m_pops.size() == 1) chk("t6_result", m_pops[0], 16'h0007);
    chk("t6_count_after", op_count, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
